// File: rtl/div_request_sequencer.sv
// Request FIFO and settle-time sequencer feeding a combinational divider.
// Divide-by-zero requests bypass the divider; results leave in request order.
module div_request_sequencer #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_by_zero,
    output logic             busy,
    output logic [7:0]       done_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] dvd_mem_q [DEPTH];
    logic [WIDTH-1:0] dvs_mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] div_dvd_q, div_dvd_d;
    logic [WIDTH-1:0] div_dvs_q, div_dvs_d;
    logic [WIDTH-1:0] out_quo_q, out_quo_d;
    logic [WIDTH-1:0] out_rem_q, out_rem_d;
    logic             out_valid_q, out_valid_d;
    logic             out_dz_q, out_dz_d;
    logic [7:0]       done_q, done_d;

    logic             push, pop, accept, not_empty, head_zero;
    logic [WIDTH-1:0] head_dvd, head_dvs;

    assign not_empty = (count_q != '0);
    assign head_dvd  = dvd_mem_q[rd_ptr_q];
    assign head_dvs  = dvs_mem_q[rd_ptr_q];
    assign head_zero = (head_dvs == '0);
    assign push      = in_valid && in_ready;
    assign accept    = (state_q == S_HOLD) && out_valid_q && out_ready;
    // HOLD pops on the accepting edge so back-to-back results skip IDLE
    assign pop       = not_empty && ((state_q == S_IDLE) || accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            div_dvd_q   <= '0;
            div_dvs_q   <= '0;
            out_quo_q   <= '0;
            out_rem_q   <= '0;
            out_valid_q <= 1'b0;
            out_dz_q    <= 1'b0;
            done_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dvd_mem_q[i] <= '0;
                dvs_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            div_dvd_q   <= div_dvd_d;
            div_dvs_q   <= div_dvs_d;
            out_quo_q   <= out_quo_d;
            out_rem_q   <= out_rem_d;
            out_valid_q <= out_valid_d;
            out_dz_q    <= out_dz_d;
            done_q      <= done_d;
            if (push) begin
                dvd_mem_q[wr_ptr_q] <= in_dividend;
                dvs_mem_q[wr_ptr_q] <= in_divisor;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (not_empty) state_d = head_zero ? S_HOLD : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (accept) begin
                    if (not_empty) state_d = head_zero ? S_HOLD : S_WAIT;
                    else           state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cnt_d       = cnt_q;
        div_dvd_d   = div_dvd_q;
        div_dvs_d   = div_dvs_q;
        out_quo_d   = out_quo_q;
        out_rem_d   = out_rem_q;
        out_valid_d = out_valid_q;
        out_dz_d    = out_dz_q;
        done_d      = done_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase

        if (state_q == S_WAIT) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                out_quo_d   = div_quotient;
                out_rem_d   = div_remainder;
                out_dz_d    = 1'b0;
                out_valid_d = 1'b1;
            end
        end

        if (accept) begin
            out_valid_d = 1'b0;
            if (done_q != 8'hFF) done_d = done_q + 8'd1;
        end

        if (pop) begin
            if (head_zero) begin
                out_quo_d   = '1;
                out_rem_d   = head_dvd;
                out_dz_d    = 1'b1;
                out_valid_d = 1'b1;
            end else begin
                div_dvd_d = head_dvd;
                div_dvs_d = head_dvs;
                cnt_d     = SETTLE_M1;
            end
        end
    end

    always_comb begin
        in_ready        = (count_q != FULL);
        busy            = (state_q != S_IDLE) || not_empty;
        div_dividend    = div_dvd_q;
        div_divisor     = div_dvs_q;
        out_valid       = out_valid_q;
        out_quotient    = out_quo_q;
        out_remainder   = out_rem_q;
        out_div_by_zero = out_dz_q;
        done_count      = done_q;
    end

endmodule
